// File: rtl/sort_job_ctrl.sv
// Job sequencer for the insertion-sort engine: loads one stream job, sorts it and drains the
// result largest-first. It is the only agent that drives the engine command pins.
module sort_job_ctrl #(
  parameter int unsigned MAX_N   = 254,
  parameter int unsigned CMD_CYC = 2,
  parameter int unsigned GUARD   = 2,
  parameter logic [15:0] PAD     = 16'hFFFF
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_enable,
  input  logic        i_s_valid,
  output logic        o_s_ready,
  input  logic [15:0] i_s_data,
  input  logic        i_s_last,
  output logic        o_m_valid,
  input  logic        i_m_ready,
  output logic [15:0] o_m_data,
  output logic        o_m_last,
  output logic        o_busy,
  output logic        o_overflow,
  output logic        o_done,
  output logic        o_e_push,
  output logic        o_e_pop,
  output logic        o_e_clear,
  output logic        o_e_sort,
  output logic [15:0] o_e_din,
  input  logic [15:0] i_e_dout,
  input  logic        i_e_idle,
  input  logic        i_e_empty,
  input  logic        i_e_full
);

  localparam int unsigned CNT_W = $clog2(MAX_N + 1);
  localparam int unsigned PH_W  = $clog2(CMD_CYC + GUARD + 1);
  localparam logic [PH_W-1:0]  PH_DROP = PH_W'(CMD_CYC - 1);
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(CMD_CYC + GUARD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_N);

  typedef enum logic [3:0] {
    StIdle, StClr, StLoad, StPush, StDrop, StPadw, StSort, StDrain, StPop, StHold, StDone
  } state_t;

  state_t           r_state;
  logic [PH_W-1:0]  r_ph;
  logic [CNT_W-1:0] r_cnt;
  logic             r_word_last;
  logic             r_s_ready;
  logic             r_m_valid;
  logic [15:0]      r_m_data;
  logic             r_m_last;
  logic             r_busy;
  logic             r_overflow;
  logic             r_done;
  logic             r_e_push;
  logic             r_e_pop;
  logic             r_e_clear;
  logic             r_e_sort;
  logic [15:0]      r_e_din;

  logic w_in_cmd;
  logic w_cmd_done;
  logic w_accept;

  assign w_in_cmd   = r_state inside {StClr, StPush, StPadw, StSort, StPop};
  assign w_cmd_done = w_in_cmd && (r_ph == PH_LAST) && i_e_idle;
  assign w_accept   = i_s_valid && r_s_ready;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state     <= StIdle;
      r_ph        <= '0;
      r_cnt       <= '0;
      r_word_last <= 1'b0;
      r_s_ready   <= 1'b0;
      r_m_valid   <= 1'b0;
      r_m_data    <= '0;
      r_m_last    <= 1'b0;
      r_busy      <= 1'b0;
      r_overflow  <= 1'b0;
      r_done      <= 1'b0;
      r_e_push    <= 1'b0;
      r_e_pop     <= 1'b0;
      r_e_clear   <= 1'b0;
      r_e_sort    <= 1'b0;
      r_e_din     <= '0;
    end else if (i_enable) begin
      r_done <= 1'b0;
      // Command phase: pin high for CMD_CYC cycles, low for GUARD, then poll idle.
      if (w_in_cmd) begin
        if (r_ph == PH_DROP) begin
          r_e_push  <= 1'b0;
          r_e_pop   <= 1'b0;
          r_e_clear <= 1'b0;
          r_e_sort  <= 1'b0;
        end
        if (r_ph != PH_LAST) r_ph <= r_ph + 1'b1;
      end
      unique case (r_state)
        StIdle: begin
          if (i_s_valid) begin
            r_state    <= StClr;
            r_busy     <= 1'b1;
            r_cnt      <= '0;
            r_overflow <= 1'b0;
            r_e_clear  <= 1'b1;
            r_ph       <= '0;
          end
        end
        StClr: begin
          if (w_cmd_done) begin
            r_state   <= StLoad;
            r_s_ready <= 1'b1;
          end
        end
        StLoad: begin
          if (w_accept) begin
            r_state     <= StPush;
            r_s_ready   <= 1'b0;
            r_e_din     <= i_s_data;
            r_word_last <= i_s_last;
            r_cnt       <= r_cnt + 1'b1;
            r_e_push    <= 1'b1;
            r_ph        <= '0;
          end
        end
        StPush: begin
          if (w_cmd_done) begin
            if (r_word_last) begin
              r_state  <= StPadw;
              r_e_din  <= PAD;
              r_e_push <= 1'b1;
              r_ph     <= '0;
            end else if (r_cnt == CNT_MAX || i_e_full) begin
              // Last word not seen yet, so more are coming: drop them through s_last.
              r_state    <= StDrop;
              r_overflow <= 1'b1;
              r_s_ready  <= 1'b1;
            end else begin
              r_state   <= StLoad;
              r_s_ready <= 1'b1;
            end
          end
        end
        StDrop: begin
          if (w_accept && i_s_last) begin
            r_state   <= StPadw;
            r_s_ready <= 1'b0;
            r_e_din   <= PAD;
            r_e_push  <= 1'b1;
            r_ph      <= '0;
          end
        end
        StPadw: begin
          if (w_cmd_done) begin
            r_state  <= StSort;
            r_e_sort <= 1'b1;
            r_ph     <= '0;
          end
        end
        StSort: begin
          if (w_cmd_done) r_state <= StDrain;
        end
        StDrain: begin
          if (i_e_empty) begin
            r_state <= StDone;
            r_done  <= 1'b1;
          end else begin
            r_state <= StPop;
            r_e_pop <= 1'b1;
            r_ph    <= '0;
          end
        end
        StPop: begin
          if (w_cmd_done) begin
            r_state   <= StHold;
            r_m_data  <= i_e_dout;
            r_m_last  <= i_e_empty;
            r_m_valid <= 1'b1;
          end
        end
        StHold: begin
          if (i_m_ready) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            if (r_m_last) begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end else begin
              r_state <= StDrain;
            end
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_s_ready  = r_s_ready;
  assign o_m_valid  = r_m_valid;
  assign o_m_data   = r_m_data;
  assign o_m_last   = r_m_last;
  assign o_busy     = r_busy;
  assign o_overflow = r_overflow;
  assign o_done     = r_done;
  assign o_e_push   = r_e_push;
  assign o_e_pop    = r_e_pop;
  assign o_e_clear  = r_e_clear;
  assign o_e_sort   = r_e_sort;
  assign o_e_din    = r_e_din;

endmodule
